msrv32_muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit, directly downstream of msrv32_integer_file.
- Consumes rs1/rs2 operand values and the decoded funct3.
- Stalls the core via busy_out while it iterates.
- Returns a 32-bit result plus destination address for register-file write-back, marked by a one-cycle done_out pulse.

---
 rtl/msrv32_muldiv_pkg.sv | 25 ++
 rtl/msrv32_muldiv_if.sv | 26 ++
 rtl/msrv32_muldiv_datapath.sv | 108 ++++++++++
 rtl/msrv32_muldiv_unit.sv | 109 ++++++++++
 tb/tb_msrv32_muldiv_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/msrv32_muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package msrv32_muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] FN_MUL    = 3'd0;
    localparam logic [2:0] FN_MULH   = 3'd1;
    localparam logic [2:0] FN_MULHSU = 3'd2;
    localparam logic [2:0] FN_MULHU  = 3'd3;
    localparam logic [2:0] FN_DIV    = 3'd4;
    localparam logic [2:0] FN_DIVU   = 3'd5;
    localparam logic [2:0] FN_REM    = 3'd6;
    localparam logic [2:0] FN_REMU   = 3'd7;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/msrv32_muldiv_if.sv
// Request/response bundle between the core and the multiply/divide unit.
interface msrv32_muldiv_if;
    import msrv32_muldiv_pkg::*;

    logic            start_in;
    logic [2:0]      funct3_in;
    logic [XLEN-1:0] rs1_in;
    logic [XLEN-1:0] rs2_in;
    logic [4:0]      rd_addr_in;
    logic            flush_in;
    logic            busy_out;
    logic            done_out;
    logic [XLEN-1:0] result_out;
    logic [4:0]      rd_addr_out;

    modport master (
        output start_in, funct3_in, rs1_in, rs2_in, rd_addr_in, flush_in,
        input  busy_out, done_out, result_out, rd_addr_out
    );

    modport slave (
        input  start_in, funct3_in, rs1_in, rs2_in, rd_addr_in, flush_in,
        output busy_out, done_out, result_out, rd_addr_out
    );

endinterface

// File: rtl/msrv32_muldiv_datapath.sv
// Magnitude conversion, one shift-add / restoring-subtract step per cycle,
// and sign correction of the final product, quotient or remainder.
// acc_q holds the product high half or the partial remainder; lo_q holds the
// multiplier being shifted out or the quotient being shifted in.
module msrv32_muldiv_datapath
    import msrv32_muldiv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] result_o
);

    logic              sgn_a, sgn_b, neg_a_in, neg_b_in;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [XLEN:0]     sum, shifted, diff;
    logic [XLEN-1:0]   mul_acc, mul_lo, div_acc, div_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // Operand signedness from funct3; INT_MIN negates to itself, i.e. 2^31 unsigned.
    always_comb begin
        if (funct3_i[2]) begin
            sgn_a = ~funct3_i[0];
            sgn_b = ~funct3_i[0];
        end else begin
            sgn_a = (funct3_i != FN_MULHU);
            sgn_b = (funct3_i == FN_MUL) || (funct3_i == FN_MULH);
        end
        neg_a_in = sgn_a & rs1_i[XLEN-1];
        neg_b_in = sgn_b & rs2_i[XLEN-1];
        mag_a    = neg_a_in ? (~rs1_i + 1'b1) : rs1_i;
        mag_b    = neg_b_in ? (~rs2_i + 1'b1) : rs2_i;
    end

    // One iteration of both algorithms; the latched funct3 picks which one is kept.
    always_comb begin
        sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_acc = sum[XLEN:1];
        mul_lo  = {sum[0], lo_q[XLEN-1:1]};
        shifted = {acc_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, opnd_q};
        div_acc = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        div_lo  = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end

    // Working-register next state: load on acceptance, step while iterating.
    always_comb begin
        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        funct3_d = funct3_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        if (load_i) begin
            acc_d    = '0;
            lo_d     = funct3_i[2] ? mag_a : mag_b;
            opnd_d   = funct3_i[2] ? mag_b : mag_a;
            funct3_d = funct3_i;
            neg_a_d  = neg_a_in;
            neg_b_d  = neg_b_in;
        end else if (step_i) begin
            acc_d = funct3_q[2] ? div_acc : mul_acc;
            lo_d  = funct3_q[2] ? div_lo  : mul_lo;
        end
    end

    // Working registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            funct3_q <= FN_MUL;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            funct3_q <= funct3_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
        end
    end

    // Result as it will be after the current step, so the last step can commit it.
    always_comb begin
        prod     = {mul_acc, mul_lo};
        prod_fix = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;
        quo_fix  = (neg_a_q ^ neg_b_q) ? (~div_lo + 1'b1) : div_lo;
        rem_fix  = neg_a_q ? (~div_acc + 1'b1) : div_acc;
        case (funct3_q)
            FN_MUL:                       result_o = prod_fix[XLEN-1:0];
            FN_MULH, FN_MULHSU, FN_MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
            FN_DIV, FN_DIVU:              result_o = quo_fix;
            default:                      result_o = rem_fix;
        endcase
    end

endmodule

// File: rtl/msrv32_muldiv_unit.sv
// Iterative RV32M execution unit: FSM, iteration counter, divide special
// cases and the write-back output registers.
//   state | meaning
//   IDLE  | waiting for start_in; operands latched on acceptance
//   BUSY  | one datapath iteration per clock, XLEN iterations
//   DONE  | result_out/rd_addr_out valid, done_out pulse
module msrv32_muldiv_unit
    import msrv32_muldiv_pkg::*;
(
    input  logic          ms_riscv32_mp_clk_in,
    input  logic          ms_riscv32_mp_rst_n_in,
    msrv32_muldiv_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rd_q, rd_d, rd_out_q, rd_out_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             load, step;
    logic             div_zero, div_ovf, special;
    logic [XLEN-1:0]  spec_res, dp_result;

    msrv32_muldiv_datapath u_datapath (
        .clk_i    (ms_riscv32_mp_clk_in),
        .rst_n_i  (ms_riscv32_mp_rst_n_in),
        .load_i   (load),
        .step_i   (step),
        .funct3_i (bus.funct3_in),
        .rs1_i    (bus.rs1_in),
        .rs2_i    (bus.rs2_in),
        .result_o (dp_result)
    );

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    always_comb begin
        div_zero = (bus.rs2_in == '0);
        div_ovf  = ~bus.funct3_in[0] && (bus.rs1_in == INT_MIN) && (bus.rs2_in == ALL_ONES);
        special  = bus.funct3_in[2] && (div_zero || div_ovf);
        if (bus.funct3_in[1]) spec_res = div_zero ? bus.rs1_in : '0;
        else                  spec_res = div_zero ? ALL_ONES : INT_MIN;
    end

    // Next state, counter, datapath control and output-register updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        rd_out_d = rd_out_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_in && !bus.flush_in) begin
                    load = 1'b1;
                    rd_d = bus.rd_addr_in;
                    if (special) begin
                        state_d  = DONE;
                        result_d = spec_res;
                        rd_out_d = bus.rd_addr_in;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = '0;
                    end
                end
            end
            BUSY: begin
                if (bus.flush_in) begin
                    state_d = IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d  = DONE;
                        result_d = dp_result;
                        rd_out_d = rd_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            result_q <= result_d;
        end
    end

    assign bus.busy_out    = (state_q != IDLE);
    assign bus.done_out    = (state_q == DONE);
    assign bus.result_out  = result_q;
    assign bus.rd_addr_out = rd_out_q;

endmodule

// File: tb/tb_msrv32_muldiv_unit.sv
// Directed bench for msrv32_muldiv_unit with a result scoreboard.
module tb_msrv32_muldiv_unit;
    import msrv32_muldiv_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msrv32_muldiv_if bus ();

    msrv32_muldiv_unit dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .bus                    (bus)
    );

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd = '0;

    function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic [63:0] ua64, ub64;
        logic        ovf;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ub   = longint'({32'd0, b});
        ua64 = {32'd0, a};
        ub64 = {32'd0, b};
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result scoreboard: every done_out pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done_out) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(bus.result_out), 64'hDEAD);
            end else begin
                e = sb_q.pop_front();
                check("result", 64'(bus.result_out), 64'(e.res));
                check("rd_addr", 64'(bus.rd_addr_out), 64'(e.rd));
                last_res = e.res;
                last_rd  = e.rd;
            end
        end
    end

    task automatic issue(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [4:0] rd, bit push);
        exp_t e;
        @(negedge clk);
        bus.start_in   = 1'b1;
        bus.funct3_in  = f;
        bus.rs1_in     = a;
        bus.rs2_in     = b;
        bus.rd_addr_in = rd;
        if (push) begin
            e.res = model(f, a, b);
            e.rd  = rd;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 bus.start_in = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done_out, bounded.
    task automatic wait_done(string tag, int exp_n);
        int n = 0;
        int busy_n = 0;
        bit got = 0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (bus.busy_out) busy_n++;
            if (bus.done_out) got = 1;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_n));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_n));
        @(negedge clk);
        check({tag, "_pulse_end"}, {62'd0, bus.done_out, bus.busy_out}, 64'd0);
    endtask

    task automatic run_op(string tag, logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
        bit spec;
        spec = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        issue(f, a, b, rd, 1'b1);
        wait_done(tag, spec ? 1 : 33);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_in   = 1'b0;
        bus.funct3_in  = '0;
        bus.rs1_in     = '0;
        bus.rs2_in     = '0;
        bus.rd_addr_in = '0;
        bus.flush_in   = 1'b0;
        #12;
        check("reset_busy", 64'(bus.busy_out), 64'd0);
        check("reset_done", 64'(bus.done_out), 64'd0);
        check("reset_result", 64'(bus.result_out), 64'd0);
        check("reset_rd", 64'(bus.rd_addr_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_neg", FN_MUL, 32'd7, 32'hFFFF_FFFD, 5'd9);
        run_op("mulh_min", FN_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1);
        run_op("mulhu_max", FN_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op("mulhsu", FN_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        run_op("div_neg", FN_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4);
        run_op("rem_neg", FN_REM, 32'hFFFF_FFF9, 32'd2, 5'd5);
        run_op("divu", FN_DIVU, 32'd100, 32'd7, 5'd6);
        run_op("remu", FN_REMU, 32'd100, 32'd7, 5'd7);
        run_op("div_zero", FN_DIV, 32'd5, 32'd0, 5'd8);
        run_op("remu_zero", FN_REMU, 32'd5, 32'd0, 5'd10);
        run_op("div_ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        run_op("rem_ovf", FN_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        run_op("divu_big", FN_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 5'd13);
        run_op("mul_x0", FN_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);

        for (int i = 0; i < 6; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i == 2) ? 32'd0 : $urandom;
            run_op("random", f, a, b, 5'(i + 20));
        end

        // start_in during BUSY must be ignored.
        issue(FN_MUL, 32'd1000, 32'd3000, 5'd14, 1'b1);
        for (int i = 1; i <= 5; i++) @(negedge clk);
        bus.start_in  = 1'b1;
        bus.funct3_in = FN_DIVU;
        bus.rs1_in    = 32'd50;
        bus.rs2_in    = 32'd0;
        @(posedge clk);
        #1 bus.start_in = 1'b0;
        wait_done("ignore_start", 28);

        // flush_in at cycle 10 of BUSY aborts without a result.
        issue(FN_DIVU, 32'd12345, 32'd17, 5'd15, 1'b0);
        for (int i = 1; i <= 10; i++) @(negedge clk);
        bus.flush_in = 1'b1;
        @(posedge clk);
        #1 bus.flush_in = 1'b0;
        check("flush_busy", 64'(bus.busy_out), 64'd0);
        check("flush_done", 64'(bus.done_out), 64'd0);
        check("flush_result_held", 64'(bus.result_out), 64'(last_res));
        check("flush_rd_held", 64'(bus.rd_addr_out), 64'(last_rd));
        run_op("after_flush", FN_REM, 32'hFFFF_FF00, 32'd7, 5'd16);

        // Asynchronous reset between edges mid-BUSY.
        issue(FN_MUL, 32'd55, 32'd66, 5'd17, 1'b1);
        for (int i = 1; i <= 7; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs", {29'd0, bus.busy_out, bus.done_out, bus.rd_addr_out, bus.result_out},
              64'd0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_reset_mul", FN_MUL, 32'd3, 32'd4, 5'd18);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
